// File: rtl/madd_sequencer_if.sv
// madd_sequencer_if: host command, DMADD and result signals between the host and the madd_sequencer.
interface madd_sequencer_if #(parameter int OUT_W = 16);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [1:0]       cmd_insn;
  logic [3:0]       cmd_index;
  logic [3:0]       cmd_data;
  logic             madd_load;
  logic             madd_run;
  logic [1:0]       madd_insn;
  logic [3:0]       madd_index;
  logic [3:0]       madd_data;
  logic [OUT_W-1:0] madd_out;
  logic             res_valid;
  logic             res_ready;
  logic [OUT_W-1:0] res_data;
  modport slave (
    input  cmd_valid, cmd_load, cmd_insn, cmd_index, cmd_data, madd_out, res_ready,
    output cmd_ready, madd_load, madd_run, madd_insn, madd_index, madd_data, res_valid, res_data
  );
  modport master (
    output cmd_valid, cmd_load, cmd_insn, cmd_index, cmd_data, madd_out, res_ready,
    input  cmd_ready, madd_load, madd_run, madd_insn, madd_index, madd_data, res_valid, res_data
  );
endinterface

// File: rtl/madd_sequencer.sv
// madd_sequencer: FIFO-buffered load/run command issue to DMADD with result capture and handshake.
// Define MADD_SEQ_OVF_EN to build the sticky overflow flag on rejected commands.
module madd_sequencer #(
  parameter int DEPTH      = 4,
  parameter int RUN_CYCLES = 8,
  parameter int OUT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  madd_sequencer_if.slave   bus,
  output logic              busy_o,
  output logic              ovf_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, RESULT} state_t;
  state_t           state_q, state_d;
  logic [AW:0]      wr_q, rd_q;
  logic [10:0]      mem [DEPTH];
  logic [10:0]      head;
  logic [9:0]       cur_q, cur_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             load_q, load_d, run_q, run_d, drain_q;
  logic [1:0]       insn_q, insn_d;
  logic [3:0]       idx_q, idx_d, dat_q, dat_d;
  logic             res_valid_q, res_valid_d;
  logic [OUT_W-1:0] res_q, res_d;
  logic             empty, full, push, pop;
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push  = bus.cmd_valid && !full;
  assign pop   = state_q == IDLE && !empty;
  assign head  = mem[rd_q[AW-1:0]];
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (!empty) begin
        cur_d   = head[9:0];
        cnt_d   = 8'(RUN_CYCLES - 1);
        state_d = head[10] ? LOAD : RUN;
      end
      LOAD:   state_d = IDLE;
      RUN: begin
        cnt_d   = cnt_q - 8'd1;
        state_d = cnt_q == 8'd0 ? DRAIN : RUN;
      end
      DRAIN:  state_d = RESULT;
      RESULT: state_d = res_valid_q && bus.res_ready ? IDLE : RESULT;
      default: state_d = IDLE;
    endcase
    // DMADD pins are registered, so they trail the state by one cycle
    load_d      = state_q == LOAD;
    run_d       = state_q == RUN;
    idx_d       = load_d ? cur_q[7:4] : 4'd0;
    dat_d       = load_d ? cur_q[3:0] : 4'd0;
    insn_d      = run_d ? cur_q[9:8] : 2'd0;
    res_valid_d = drain_q || (res_valid_q && !bus.res_ready);
    res_d       = drain_q ? bus.madd_out : res_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      cur_q       <= '0;
      cnt_q       <= '0;
      load_q      <= 1'b0;
      run_q       <= 1'b0;
      drain_q     <= 1'b0;
      insn_q      <= '0;
      idx_q       <= '0;
      dat_q       <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_q + {{AW{1'b0}}, push};
      rd_q        <= rd_q + {{AW{1'b0}}, pop};
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      load_q      <= load_d;
      run_q       <= run_d;
      drain_q     <= state_q == DRAIN;
      insn_q      <= insn_d;
      idx_q       <= idx_d;
      dat_q       <= dat_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_q[AW-1:0]] <= {bus.cmd_load, bus.cmd_insn, bus.cmd_index, bus.cmd_data};
  end
`ifdef MADD_SEQ_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_q || (bus.cmd_valid && full);
  end
  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif
  assign bus.cmd_ready  = !full;
  assign bus.madd_load  = load_q;
  assign bus.madd_run   = run_q;
  assign bus.madd_insn  = insn_q;
  assign bus.madd_index = idx_q;
  assign bus.madd_data  = dat_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_q;
  assign busy_o = !empty || state_q != IDLE || load_q || run_q;
endmodule

// File: tb/tb_madd_sequencer.sv
// tb_madd_sequencer: directed checks of load/run issue timing, backpressure, full FIFO, reset and wrap.
module tb_madd_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic busy, ovf;
  int   errs = 0;
  int   checks = 0;
  madd_sequencer_if #(.OUT_W(16)) bus ();
  madd_sequencer #(.DEPTH(4), .RUN_CYCLES(8), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy_o(busy), .ovf_o(ovf)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic ld, input logic [1:0] insn, input logic [3:0] idx, input logic [3:0] dat);
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = ld;
    bus.cmd_insn  = insn;
    bus.cmd_index = idx;
    bus.cmd_data  = dat;
    tick();
    bus.cmd_valid = 1'b0;
  endtask
  function automatic logic [10:0] wcmd(input int i);
    logic [3:0] a, b;
    logic [1:0] n;
    a = 4'(i);
    b = 4'(15 - i);
    n = 2'(i % 4);
    return (i % 2 == 0) ? {1'b1, 2'b00, a, b} : {1'b0, n, 8'h00};
  endfunction
  initial begin
    logic [10:0] obs[$];
    logic        prev_run;
    logic        acc;
    int          pi, n_load, n_run, n_bad;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_load = 1'b0; bus.cmd_insn = '0;
    bus.cmd_index = '0; bus.cmd_data = '0; bus.res_ready = 1'b1; bus.madd_out = '0;
    tick(); tick();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_madd_load", 32'(bus.madd_load), 0);
    chk("rst_madd_run", 32'(bus.madd_run), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_data", 32'(bus.res_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst = 1'b0;
    tick();
    // single load command
    push(1'b1, 2'd0, 4'd3, 4'd9);
    chk("load_c0", 32'(bus.madd_load), 0);
    tick();
    chk("load_c1", 32'(bus.madd_load), 0);
    tick();
    chk("load_c2", 32'(bus.madd_load), 1);
    chk("load_c2_index", 32'(bus.madd_index), 3);
    chk("load_c2_data", 32'(bus.madd_data), 9);
    tick();
    chk("load_c3", 32'(bus.madd_load), 0);
    chk("load_c3_index", 32'(bus.madd_index), 0);
    chk("load_c3_busy", 32'(busy), 0);
    // single run command
    bus.madd_out = 16'h1234;
    push(1'b0, 2'd2, 4'd0, 4'd0);
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("run_c%0d_run", c), 32'(bus.madd_run), (c >= 2 && c <= 9) ? 1 : 0);
      chk($sformatf("run_c%0d_insn", c), 32'(bus.madd_insn), (c >= 2 && c <= 9) ? 2 : 0);
      chk($sformatf("run_c%0d_valid", c), 32'(bus.res_valid), (c == 11) ? 1 : 0);
      if (c == 11) chk("run_res_data", 32'(bus.res_data), 32'h1234);
    end
    chk("run_res_hold", 32'(bus.res_data), 32'h1234);
    chk("run_busy_end", 32'(busy), 0);
    // backpressure with FIFO filling behind a pending result
    bus.res_ready = 1'b0;
    bus.madd_out  = 16'hABCD;
    push(1'b0, 2'd1, 4'd0, 4'd0);
    repeat (11) tick();
    chk("bp_valid", 32'(bus.res_valid), 1);
    chk("bp_data", 32'(bus.res_data), 32'hABCD);
    bus.madd_out = 16'h0000;
    for (int k = 1; k <= 5; k++) begin
      push(1'b1, 2'd0, (k == 5) ? 4'd15 : 4'(k), (k == 5) ? 4'd15 : 4'(k + 4));
      chk($sformatf("bp_ready_%0d", k), 32'(bus.cmd_ready), (k < 4) ? 1 : 0);
      chk($sformatf("bp_valid_%0d", k), 32'(bus.res_valid), 1);
      chk($sformatf("bp_data_%0d", k), 32'(bus.res_data), 32'hABCD);
      chk($sformatf("bp_noissue_%0d", k), 32'({bus.madd_load, bus.madd_run}), 0);
    end
`ifdef MADD_SEQ_OVF_EN
    chk("ovf_set", 32'(ovf), 1);
`else
    chk("ovf_off", 32'(ovf), 0);
`endif
    tick();
    bus.res_ready = 1'b1;
    tick();
    chk("bp_handshake", 32'(bus.res_valid), 0);
    chk("bp_data_after", 32'(bus.res_data), 32'hABCD);
    n_load = 0; n_run = 0;
    obs.delete();
    for (int c = 0; c < 20; c++) begin
      if (bus.madd_load) obs.push_back({1'b1, 2'b00, bus.madd_index, bus.madd_data});
      if (bus.madd_run) n_run++;
      tick();
    end
    chk("bp_load_count", 32'(obs.size()), 4);
    chk("bp_run_count", 32'(n_run), 0);
    for (int k = 0; k < 4 && k < obs.size(); k++)
      chk($sformatf("bp_load_%0d", k), 32'(obs[k]), 32'({1'b1, 2'b00, 4'(k + 1), 4'(k + 5)}));
    // pointer wrap: stream of alternating load/run commands
    obs.delete();
    pi = 0;
    prev_run = 1'b0;
    bus.madd_out = 16'h5555;
    for (int c = 0; c < 400 && obs.size() < 10; c++) begin
      bus.cmd_valid = pi < 10;
      {bus.cmd_load, bus.cmd_insn, bus.cmd_index, bus.cmd_data} = wcmd(pi < 10 ? pi : 0);
      acc = bus.cmd_valid && bus.cmd_ready;
      tick();
      if (acc) pi++;
      if (bus.madd_load) obs.push_back({1'b1, 2'b00, bus.madd_index, bus.madd_data});
      if (bus.madd_run && !prev_run) obs.push_back({1'b0, bus.madd_insn, 8'h00});
      prev_run = bus.madd_run;
    end
    bus.cmd_valid = 1'b0;
    chk("wrap_count", 32'(obs.size()), 10);
    for (int k = 0; k < 10 && k < obs.size(); k++)
      chk($sformatf("wrap_cmd_%0d", k), 32'(obs[k]), 32'(wcmd(k)));
    repeat (20) tick();
    chk("wrap_idle", 32'(busy), 0);
    // asynchronous reset in the middle of a run, with a load queued behind it
    push(1'b0, 2'd3, 4'd0, 4'd0);
    push(1'b1, 2'd0, 4'd7, 4'd7);
    repeat (4) tick();
    chk("mid_run_active", 32'(bus.madd_run), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_run", 32'(bus.madd_run), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(bus.cmd_ready), 1);
    chk("mid_rst_valid", 32'(bus.res_valid), 0);
    tick();
    rst = 1'b0;
    n_bad = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus.res_valid || bus.madd_load || bus.madd_run || busy) n_bad++;
    end
    chk("post_rst_quiet", 32'(n_bad), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
